// File: rtl/ece593w26_mac_pkg.sv
// ---------------------------------------------------------------------------
// ece593w26_mac_pkg
// Shared types and defaults for the MAC scheduler slice.
//   sched_state_t   : scheduler FSM states
//   MAC_LAT_DEFAULT : default MAC pipeline latency / flush length
//   id_width()      : width of a requester index for a given requester count
// ---------------------------------------------------------------------------
package ece593w26_mac_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_RESP   = 3'd4
    } sched_state_t;

    localparam int MAC_LAT_DEFAULT = 3;
    localparam int NREQ_DEFAULT    = 4;

    // A single requester still needs a 1-bit index field.
    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    localparam int ID_W_DEFAULT = id_width(NREQ_DEFAULT);

endpackage

// File: rtl/ece593w26_mac.sv
// ---------------------------------------------------------------------------
// ece593w26_mac
// Signed multiply-accumulate datapath shared by the scheduler.
//   clk : clock
//   rst : synchronous active-high clear of pipeline and accumulator
//   w,x : signed N-bit operands
//   f   : 2N-bit accumulator, wraps modulo 2^(2N)
// MAC_LAT is counted from the scheduler's operand handshake: the scheduler's
// own operand register is the first stage, so this block adds MAC_LAT-1
// register stages (MAC_LAT-2 product stages, then the accumulator).
// ---------------------------------------------------------------------------
module ece593w26_mac #(
    parameter int N       = 8,
    parameter int MAC_LAT = 3
)(
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   w,
    input  logic [N-1:0]   x,
    output logic [2*N-1:0] f
);

    localparam int PD = MAC_LAT - 2;

    logic [2*N-1:0] w_ext;
    logic [2*N-1:0] x_ext;
    logic [2*N-1:0] prod;
    logic [2*N-1:0] acc_reg;

    // Sign-extending both operands makes the low 2N bits of an unsigned
    // product equal to the signed product.
    assign w_ext = {{N{w[N-1]}}, w};
    assign x_ext = {{N{x[N-1]}}, x};
    assign prod  = w_ext * x_ext;
    assign f     = acc_reg;

    generate
        if (PD < 1) begin : g_direct
            always_ff @(posedge clk) begin
                if (rst) acc_reg <= '0;
                else     acc_reg <= acc_reg + prod;
            end
        end else begin : g_pipe
            logic [2*N-1:0] p_reg [PD];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PD; i++) p_reg[i] <= '0;
                    acc_reg <= '0;
                end else begin
                    p_reg[0] <= prod;
                    for (int i = 1; i < PD; i++) p_reg[i] <= p_reg[i-1];
                    acc_reg <= acc_reg + p_reg[PD-1];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ece593w26_rr_arb.sv
// ---------------------------------------------------------------------------
// ece593w26_rr_arb
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index this round
//   gnt : one-hot grant of the first request at or after ptr (wrapping)
//   idx : binary index of that grant
//   any : at least one request present
// ---------------------------------------------------------------------------
module ece593w26_rr_arb
    import ece593w26_mac_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = id_width(NREQ)
)(
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    always_comb begin
        int             s;
        logic [ID_W-1:0] sel;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        s   = 0;
        sel = '0;
        // Walk candidates in priority order starting at ptr; first hit wins.
        for (int k = 0; k < NREQ; k++) begin
            s = int'(ptr) + k;
            if (s >= NREQ) s = s - NREQ;
            sel = ID_W'(s);
            if (!any && req[sel]) begin
                any      = 1'b1;
                idx      = sel;
                gnt[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ece593w26_mac_sched.sv
// ---------------------------------------------------------------------------
// ece593w26_mac_sched
// Round-robin scheduler sharing one MAC among NREQ requesters. Each job:
// clear MAC, stream len operand pairs, drain the pipeline, return the result.
//   clk, rst           : clock, asynchronous active-low reset
//   req_valid/req_len  : per-requester job request and pair count
//   op_valid/op_w/op_x : per-requester operand stream
//   op_ready           : accept strobe for the granted requester (combinational)
//   gnt                : one-hot grant, held for the whole job
//   mac_clr/mac_w/mac_x: MAC clear and operands
//   mac_f              : MAC accumulator
//   res_valid/res_id/res_data/res_ready : result handshake
// ---------------------------------------------------------------------------
module ece593w26_mac_sched
    import ece593w26_mac_pkg::*;
#(
    parameter int  N       = 8,
    parameter int  NREQ    = 4,
    parameter int  LEN_W   = 4,
    parameter int  MAC_LAT = MAC_LAT_DEFAULT,
    localparam int ID_W    = id_width(NREQ)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [NREQ-1:0]       op_valid,
    input  logic [NREQ*N-1:0]     op_w,
    input  logic [NREQ*N-1:0]     op_x,
    output logic [NREQ-1:0]       op_ready,
    output logic [NREQ-1:0]       gnt,
    output logic                  mac_clr,
    output logic [N-1:0]          mac_w,
    output logic [N-1:0]          mac_x,
    input  logic [2*N-1:0]        mac_f,
    output logic                  res_valid,
    output logic [ID_W-1:0]       res_id,
    output logic [2*N-1:0]        res_data,
    input  logic                  res_ready
);

    localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    sched_state_t     state_reg, state_next;
    logic [ID_W-1:0]  id_reg, id_next;
    logic [ID_W-1:0]  ptr_reg, ptr_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic [LAT_W-1:0] lat_reg, lat_next;
    logic [NREQ-1:0]  gnt_reg, gnt_next;
    logic             mac_clr_reg, mac_clr_next;
    logic [N-1:0]     mac_w_reg, mac_w_next;
    logic [N-1:0]     mac_x_reg, mac_x_next;
    logic             res_valid_reg, res_valid_next;
    logic [ID_W-1:0]  res_id_reg, res_id_next;
    logic [2*N-1:0]   res_data_reg, res_data_next;

    logic [NREQ-1:0]  arb_gnt;
    logic [ID_W-1:0]  arb_idx;
    logic             arb_any;
    logic             op_fire;

    logic [LEN_W-1:0] req_len_arr [NREQ];
    logic [N-1:0]     op_w_arr    [NREQ];
    logic [N-1:0]     op_x_arr    [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_len_arr[gi] = req_len[gi*LEN_W +: LEN_W];
            assign op_w_arr[gi]    = op_w[gi*N +: N];
            assign op_x_arr[gi]    = op_x[gi*N +: N];
        end
    endgenerate

    ece593w26_rr_arb #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_reg),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // gnt_reg is the one-hot of id_reg for the whole job, so it doubles as
    // the ready mask while streaming.
    assign op_ready = (state_reg == S_STREAM) ? gnt_reg : '0;
    assign op_fire  = (state_reg == S_STREAM) && op_valid[id_reg];

    assign gnt       = gnt_reg;
    assign mac_clr   = mac_clr_reg;
    assign mac_w     = mac_w_reg;
    assign mac_x     = mac_x_reg;
    assign res_valid = res_valid_reg;
    assign res_id    = res_id_reg;
    assign res_data  = res_data_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            id_reg        <= '0;
            ptr_reg       <= '0;
            cnt_reg       <= '0;
            lat_reg       <= '0;
            gnt_reg       <= '0;
            mac_clr_reg   <= 1'b1;
            mac_w_reg     <= '0;
            mac_x_reg     <= '0;
            res_valid_reg <= 1'b0;
            res_id_reg    <= '0;
            res_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            id_reg        <= id_next;
            ptr_reg       <= ptr_next;
            cnt_reg       <= cnt_next;
            lat_reg       <= lat_next;
            gnt_reg       <= gnt_next;
            mac_clr_reg   <= mac_clr_next;
            mac_w_reg     <= mac_w_next;
            mac_x_reg     <= mac_x_next;
            res_valid_reg <= res_valid_next;
            res_id_reg    <= res_id_next;
            res_data_reg  <= res_data_next;
        end
    end

    // Registered outputs are computed as the value they must hold in the
    // state being entered.
    always_comb begin
        state_next     = state_reg;
        id_next        = id_reg;
        ptr_next       = ptr_reg;
        cnt_next       = cnt_reg;
        lat_next       = lat_reg;
        gnt_next       = gnt_reg;
        mac_clr_next   = 1'b0;
        mac_w_next     = '0;
        mac_x_next     = '0;
        res_valid_next = res_valid_reg;
        res_id_next    = res_id_reg;
        res_data_next  = res_data_reg;

        case (state_reg)
            S_IDLE: begin
                gnt_next = '0;
                if (arb_any) begin
                    id_next      = arb_idx;
                    cnt_next     = req_len_arr[arb_idx];
                    lat_next     = '0;
                    gnt_next     = arb_gnt;
                    mac_clr_next = 1'b1;
                    state_next   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (lat_reg == LAT_W'(MAC_LAT - 1)) begin
                    lat_next   = '0;
                    state_next = (cnt_reg == '0) ? S_DRAIN : S_STREAM;
                end else begin
                    lat_next     = lat_reg + LAT_W'(1);
                    mac_clr_next = 1'b1;
                end
            end
            S_STREAM: begin
                if (op_fire) begin
                    mac_w_next = op_w_arr[id_reg];
                    mac_x_next = op_x_arr[id_reg];
                    cnt_next   = cnt_reg - LEN_W'(1);
                    if (cnt_reg == LEN_W'(1)) begin
                        lat_next   = '0;
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (lat_reg == LAT_W'(MAC_LAT - 1)) begin
                    res_valid_next = 1'b1;
                    res_data_next  = mac_f;
                    res_id_next    = id_reg;
                    lat_next       = '0;
                    state_next     = S_RESP;
                end else begin
                    lat_next = lat_reg + LAT_W'(1);
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    res_valid_next = 1'b0;
                    gnt_next       = '0;
                    ptr_next       = (id_reg == ID_W'(NREQ - 1)) ? '0 : id_reg + ID_W'(1);
                    state_next     = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ece593w26_mac_sched.sv
// ---------------------------------------------------------------------------
// tb_ece593w26_mac_sched
// Directed and randomized jobs for the MAC scheduler with a real MAC attached.
// Expected grants come from a round-robin pick over the pending-request set;
// expected results from a plain signed dot product truncated to 2N bits.
// ---------------------------------------------------------------------------
module tb_ece593w26_mac_sched;

    localparam int N     = 8;
    localparam int NREQ  = 4;
    localparam int LEN_W = 4;
    localparam int LAT   = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*LEN_W-1:0] req_len   = '0;
    logic [NREQ-1:0]       op_valid  = '0;
    logic [NREQ*N-1:0]     op_w      = '0;
    logic [NREQ*N-1:0]     op_x      = '0;
    logic [NREQ-1:0]       op_ready;
    logic [NREQ-1:0]       gnt;
    logic                  mac_clr;
    logic [N-1:0]          mac_w;
    logic [N-1:0]          mac_x;
    logic [2*N-1:0]        mac_f;
    logic                  res_valid;
    logic [1:0]            res_id;
    logic [2*N-1:0]        res_data;
    logic                  res_ready = 1'b0;

    ece593w26_mac_sched #(
        .N       (N),
        .NREQ    (NREQ),
        .LEN_W   (LEN_W),
        .MAC_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_len   (req_len),
        .op_valid  (op_valid),
        .op_w      (op_w),
        .op_x      (op_x),
        .op_ready  (op_ready),
        .gnt       (gnt),
        .mac_clr   (mac_clr),
        .mac_w     (mac_w),
        .mac_x     (mac_x),
        .mac_f     (mac_f),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .res_ready (res_ready)
    );

    ece593w26_mac #(
        .N       (N),
        .MAC_LAT (LAT)
    ) u_mac (
        .clk (clk),
        .rst (mac_clr),
        .w   (mac_w),
        .x   (mac_x),
        .f   (mac_f)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_job  = 0;

    // Reference model state
    int        ptr_m = 0;
    logic [3:0] pend  = '0;
    logic [3:0] rearm = '0;
    int        len_tab [NREQ];
    byte       w_tab   [NREQ][16];
    byte       x_tab   [NREQ][16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] m, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] dot(input int r);
        int s;
        s = 0;
        for (int k = 0; k < len_tab[r]; k++) s += int'(w_tab[r][k]) * int'(x_tab[r][k]);
        return 16'(s);
    endfunction

    task automatic arm(input int r);
        req_len[r*LEN_W +: LEN_W] = LEN_W'(len_tab[r]);
        req_valid[r] = 1'b1;
        pend[r]      = 1'b1;
    endtask

    task automatic fill_random(input int r, input int len);
        len_tab[r] = len;
        for (int k = 0; k < 16; k++) begin
            w_tab[r][k] = byte'($urandom);
            x_tab[r][k] = byte'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        op_valid  = '0;
        res_ready = 1'b0;
        #1;
        chk("rst_mac_clr", mac_clr, 1);
        chk("rst_gnt", gnt, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_op_ready", op_ready, 0);
        repeat (3) @(negedge clk);
        chk("rst_hold_mac_clr", mac_clr, 1);
        rst   = 1'b1;
        ptr_m = 0;
        pend  = '0;
        rearm = '0;
        @(negedge clk);
        chk("post_rst_gnt", gnt, 0);
        chk("post_rst_res_valid", res_valid, 0);
        chk("post_rst_mac_clr", mac_clr, 0);
    endtask

    // Called at a falling edge inside an IDLE cycle, right after requests are set.
    // bub: 0 back-to-back, 1 alternate cycles, 2 random bubbles.
    task automatic serve(input int bub, input int hold, input bit chk_lat,
                         input bit disturb, output int g_out);
        int          g, t0, sent, mclr, lat;
        bit          seen_g, tog, v;
        logic [3:0]  one_g;
        logic [15:0] exp_d;
        t0     = cyc;
        g      = rr_pick(pend, ptr_m);
        g_out  = g;
        if (g < 0) begin
            chk("no_pending", 0, 1);
            return;
        end
        one_g    = '0;
        one_g[g] = 1'b1;
        exp_d    = dot(g);
        sent = 0; mclr = 0; seen_g = 1'b0; tog = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            op_valid = '0;
            if (res_valid) break;
            if (mac_clr) mclr++;
            if (gnt != '0) begin
                chk("gnt_onehot", gnt, one_g);
                if (!seen_g && disturb) begin
                    req_len[g*LEN_W +: LEN_W] = LEN_W'($urandom);
                    if ($urandom_range(0, 1) == 1) req_valid[g] = 1'b0;
                end
                seen_g = 1'b1;
            end
            if (op_ready != '0) begin
                chk("op_ready_sel", op_ready, (sent < len_tab[g]) ? one_g : 4'b0000);
                if (op_ready[g] && sent < len_tab[g]) begin
                    case (bub)
                        0:       v = 1'b1;
                        1:       begin v = tog; tog = ~tog; end
                        default: v = ($urandom_range(0, 1) == 1);
                    endcase
                    if (v) begin
                        op_valid[g]      = 1'b1;
                        op_w[g*N +: N]   = w_tab[g][sent];
                        op_x[g*N +: N]   = x_tab[g][sent];
                        sent++;
                    end
                end
            end
        end
        lat = cyc - t0;
        chk("res_valid", res_valid, 1);
        chk("gnt_seen", seen_g, 1);
        chk("mac_clr_cycles", mclr, LAT);
        chk("pairs_sent", sent, len_tab[g]);
        chk("res_id", res_id, g);
        chk("res_data", res_data, exp_d);
        chk("gnt_in_resp", gnt, one_g);
        if (chk_lat && bub == 0) chk("latency", lat, 2*LAT + len_tab[g] + 1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", res_valid, 1);
            chk("hold_id", res_id, g);
            chk("hold_data", res_data, exp_d);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
        chk("gnt_drop", gnt, 0);
        ptr_m = (g + 1) % NREQ;
        if (!rearm[g]) begin
            pend[g]      = 1'b0;
            req_valid[g] = 1'b0;
        end
        n_job++;
        $display("job %0d: req=%0d len=%0d bub=%0d hold=%0d data=%04h expected=%04h latency=%0d",
                 n_job, g, len_tab[g], bub, hold, res_data, exp_d, lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int sent_i;
        int exp_order [5];
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2;
        exp_order[3] = 3; exp_order[4] = 0;

        // Reset behaviour
        do_reset();

        // Requester 2, three pairs: 2*3 + 4*5 + (-1)*6 = 20
        len_tab[2] = 3;
        w_tab[2][0] = 2;  x_tab[2][0] = 3;
        w_tab[2][1] = 4;  x_tab[2][1] = 5;
        w_tab[2][2] = -1; x_tab[2][2] = 6;
        arm(2);
        serve(0, 0, 1'b1, 1'b0, g);
        chk("single_id", g, 2);
        chk("single_value", dot(2), 20);

        // All four requesting continuously, one (1,1) pair each
        do_reset();
        for (int r = 0; r < NREQ; r++) begin
            len_tab[r] = 1;
            w_tab[r][0] = 1;
            x_tab[r][0] = 1;
            arm(r);
        end
        rearm = 4'hF;
        for (int j = 0; j < 5; j++) begin
            serve(0, 1, 1'b1, 1'b0, g);
            chk("rr_order", g, exp_order[j]);
        end
        rearm     = '0;
        pend      = '0;
        req_valid = '0;

        // Requester 1 with a zero-length job
        len_tab[1] = 0;
        arm(1);
        serve(0, 0, 1'b1, 1'b0, g);

        // Requester 1, (3,3) x4 with every-other-cycle valid, result held 5 cycles
        len_tab[1] = 4;
        for (int k = 0; k < 4; k++) begin
            w_tab[1][k] = 3;
            x_tab[1][k] = 3;
        end
        arm(1);
        serve(1, 5, 1'b0, 1'b0, g);
        chk("bubble_value", dot(1), 36);

        // Asynchronous reset in the middle of streaming
        do_reset();
        len_tab[0] = 5;
        for (int k = 0; k < 5; k++) begin
            w_tab[0][k] = 7;
            x_tab[0][k] = 9;
        end
        arm(0);
        sent_i = 0;
        for (int c = 0; c < 30 && sent_i < 2; c++) begin
            @(negedge clk);
            op_valid = '0;
            if (op_ready[0]) begin
                op_valid[0] = 1'b1;
                op_w[N-1:0] = w_tab[0][sent_i];
                op_x[N-1:0] = x_tab[0][sent_i];
                sent_i++;
            end
        end
        chk("pre_abort_pairs", sent_i, 2);
        @(negedge clk);
        op_valid = '0;
        #2 rst = 1'b0;
        #1;
        chk("abort_gnt", gnt, 0);
        chk("abort_op_ready", op_ready, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_mac_clr", mac_clr, 1);
        req_valid = '0;
        pend      = '0;
        repeat (2) @(negedge clk);
        chk("abort_no_result", res_valid, 0);
        rst   = 1'b1;
        ptr_m = 0;
        @(negedge clk);
        fill_random(2, 2);
        arm(2);
        serve(0, 0, 1'b1, 1'b0, g);

        // Randomized traffic: overlapping requests, random lengths, bubbles,
        // back-pressure, and mid-job req_valid/req_len disturbance.
        for (int it = 0; it < 24; it++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    fill_random(r, $urandom_range(0, 15));
                    arm(r);
                end
            end
            if (pend == '0) begin
                sent_i = $urandom_range(0, NREQ - 1);
                fill_random(sent_i, $urandom_range(0, 15));
                arm(sent_i);
            end
            serve($urandom_range(0, 2), $urandom_range(0, 3), 1'b1, 1'b1, g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
